// File: rtl/path_delay_monitor_pkg.sv
// Shared definitions for path_delay_monitor: FSM state encoding and the
// lowest-set-bit priority helper used to pick the reported source input.
package path_delay_monitor_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_COUNT
  } state_t;

  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    lowest_set = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/chg_detect.sv
// Registered change detector: diff flags the bits of d that differ from the
// previous cycle's value. Reset loads the current value so no false edge follows.
module chg_detect #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] diff
);

  logic [W-1:0] prev;

  always_ff @(posedge clock) begin
    prev <= d;
    if (reset) diff <= '0;
    else       diff <= d ^ prev;
  end

endmodule

// File: rtl/path_delay_monitor.sv
// Measures cycles from a stimulus change to the response change and flags
// over-limit delays. Define PATH_DELAY_MAX_TRACK_EN to build the max_delay tracker.
module path_delay_monitor
  import path_delay_monitor_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int CNT_W   = 8,
  parameter int SPLIT   = 2,
  parameter int LIM_A   = 15,
  parameter int LIM_B   = 12,
  parameter int TIMEOUT = 63,
  localparam int SRC_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IN-1:0]  stim,
  input  logic             resp,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_delay,
  output logic [SRC_W-1:0] meas_src,
  output logic             meas_multi,
  output logic             no_resp,
  output logic             viol,
  output logic             spurious,
  output logic [CNT_W-1:0] retrig_cnt,
  output logic [CNT_W-1:0] max_delay
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [N_IN-1:0]  s_diff;
  logic             r_diff;
  logic             s_chg, r_chg;
  logic [SRC_W-1:0] new_src;
  logic             new_multi;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SRC_W-1:0] cur_src, src_nxt;
  logic             cur_multi, multi_nxt;

  logic             rep, rep_timeout, rep_multi, rep_viol;
  logic [CNT_W-1:0] rep_delay;
  logic [SRC_W-1:0] rep_src;
  logic             spur_nxt, retrig_inc;

  chg_detect #(.W(N_IN)) u_stim_chg (
    .clock (clock),
    .reset (reset),
    .d     (stim),
    .diff  (s_diff)
  );

  chg_detect #(.W(1)) u_resp_chg (
    .clock (clock),
    .reset (reset),
    .d     (resp),
    .diff  (r_diff)
  );

  assign s_chg     = |s_diff;
  assign r_chg     = r_diff;
  assign new_src   = SRC_W'(lowest_set(32'(s_diff)));
  assign new_multi = ($countones(s_diff) > 1);

  function automatic logic over_limit(input logic [SRC_W-1:0] src,
                                      input logic [CNT_W-1:0] d);
    if (32'(src) < SPLIT) return (32'(d) > LIM_A);
    else                  return (32'(d) > LIM_B);
  endfunction

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    src_nxt     = cur_src;
    multi_nxt   = cur_multi;
    rep         = 1'b0;
    rep_timeout = 1'b0;
    rep_delay   = cnt;
    rep_src     = cur_src;
    rep_multi   = cur_multi;
    spur_nxt    = 1'b0;
    retrig_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_chg && r_chg) begin
          rep       = 1'b1;
          rep_delay = '0;
          rep_src   = new_src;
          rep_multi = new_multi;
        end else if (s_chg) begin
          src_nxt   = new_src;
          multi_nxt = new_multi;
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_COUNT;
        end else if (r_chg) begin
          spur_nxt = 1'b1;
        end
      end
      ST_COUNT: begin
        // A stimulus change always restarts the count from the new source,
        // whether or not the old measurement completed this same cycle.
        if (r_chg || s_chg) begin
          rep = r_chg;
          if (s_chg) begin
            retrig_inc = !r_chg;
            src_nxt    = new_src;
            multi_nxt  = new_multi;
            cnt_nxt    = CNT_W'(1);
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (cnt == TIMEOUT_C) begin
          rep         = 1'b1;
          rep_timeout = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    rep_viol = !rep_timeout && over_limit(rep_src, rep_delay);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cur_src    <= '0;
      cur_multi  <= 1'b0;
      meas_valid <= 1'b0;
      meas_delay <= '0;
      meas_src   <= '0;
      meas_multi <= 1'b0;
      no_resp    <= 1'b0;
      viol       <= 1'b0;
      spurious   <= 1'b0;
      retrig_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur_src    <= src_nxt;
      cur_multi  <= multi_nxt;
      meas_valid <= rep;
      spurious   <= spur_nxt;
      if (rep) begin
        meas_delay <= rep_delay;
        meas_src   <= rep_src;
        meas_multi <= rep_multi;
        no_resp    <= rep_timeout;
        viol       <= rep_viol;
      end
      if (retrig_inc && (retrig_cnt != '1)) retrig_cnt <= retrig_cnt + 1'b1;
    end
  end

`ifdef PATH_DELAY_MAX_TRACK_EN
  always_ff @(posedge clock) begin
    if (reset)
      max_delay <= '0;
    else if (rep && !rep_timeout && (rep_delay > max_delay))
      max_delay <= rep_delay;
  end
`else
  assign max_delay = '0;
`endif

endmodule

// File: tb/tb_path_delay_monitor.sv
// Scoreboard bench for path_delay_monitor: scenario tasks push expected
// reports/spurious pulses, a negedge monitor pops and compares them.
module tb_path_delay_monitor;

  localparam int N_IN    = 4;
  localparam int CNT_W   = 8;
  localparam int SPLIT   = 2;
  localparam int LIM_A   = 15;
  localparam int LIM_B   = 12;
  localparam int TIMEOUT = 63;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N_IN-1:0]  stim  = '0;
  logic             resp  = 1'b0;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_delay;
  logic [1:0]       meas_src;
  logic             meas_multi;
  logic             no_resp;
  logic             viol;
  logic             spurious;
  logic [CNT_W-1:0] retrig_cnt;
  logic [CNT_W-1:0] max_delay;

  typedef struct {
    bit is_spur;
    int delay;
    int src;
    bit multi;
    bit no_resp;
    bit viol;
  } exp_t;

  exp_t exp_q[$];
  int   checks       = 0;
  int   failures     = 0;
  int   retrig_model = 0;
  int   max_model    = 0;

  path_delay_monitor #(
    .N_IN(N_IN), .CNT_W(CNT_W), .SPLIT(SPLIT),
    .LIM_A(LIM_A), .LIM_B(LIM_B), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .stim       (stim),
    .resp       (resp),
    .meas_valid (meas_valid),
    .meas_delay (meas_delay),
    .meas_src   (meas_src),
    .meas_multi (meas_multi),
    .no_resp    (no_resp),
    .viol       (viol),
    .spurious   (spurious),
    .retrig_cnt (retrig_cnt),
    .max_delay  (max_delay)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int lowest_bit(input logic [N_IN-1:0] m);
    for (int i = 0; i < N_IN; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int expected_max();
`ifdef PATH_DELAY_MAX_TRACK_EN
    return max_model;
`else
    return 0;
`endif
  endfunction

  task automatic push_report(input logic [N_IN-1:0] mask, input int d, input bit timeout);
    exp_t e;
    int   lim;
    e.is_spur = 1'b0;
    e.src     = lowest_bit(mask);
    e.multi   = ($countones(mask) > 1);
    e.no_resp = timeout;
    e.delay   = timeout ? TIMEOUT : d;
    lim       = (e.src < SPLIT) ? LIM_A : LIM_B;
    e.viol    = !timeout && (d > lim);
    exp_q.push_back(e);
    if (!timeout && d > max_model) max_model = d;
  endtask

  task automatic push_spur();
    exp_t e;
    e.is_spur = 1'b1;
    e.delay   = 0;
    e.src     = 0;
    e.multi   = 1'b0;
    e.no_resp = 1'b0;
    e.viol    = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Launch with mask; respond d cycles later (d==0 means same cycle), or never.
  task automatic applyStimulus(input logic [N_IN-1:0] mask, input int d, input bit respond);
    wait_cycles(1);
    stim = stim ^ mask;
    if (respond && d == 0) begin
      resp = ~resp;
      push_report(mask, 0, 1'b0);
    end else if (respond) begin
      if (d > TIMEOUT) push_report(mask, 0, 1'b1);
      else             push_report(mask, d, 1'b0);
      wait_cycles(d);
      resp = ~resp;
      if (d > TIMEOUT) push_spur();
    end else begin
      push_report(mask, 0, 1'b1);
      wait_cycles(TIMEOUT + 4);
    end
    wait_cycles(4);
  endtask

  task automatic applyRetrig(input logic [N_IN-1:0] m1, input int k,
                             input logic [N_IN-1:0] m2, input int d);
    wait_cycles(1);
    stim = stim ^ m1;
    wait_cycles(k);
    stim = stim ^ m2;
    if (retrig_model < 255) retrig_model++;
    push_report(m2, d, 1'b0);
    wait_cycles(d);
    resp = ~resp;
    wait_cycles(4);
  endtask

  task automatic applySpurious();
    wait_cycles(1);
    resp = ~resp;
    push_spur();
    wait_cycles(4);
  endtask

  task automatic check_counters();
    checkOutput("retrig_cnt", int'(retrig_cnt), retrig_model);
    checkOutput("max_delay", int'(max_delay), expected_max());
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"}, int'(meas_valid), 0);
    checkOutput({tag, "_delay"}, int'(meas_delay), 0);
    checkOutput({tag, "_src"}, int'(meas_src), 0);
    checkOutput({tag, "_multi"}, int'(meas_multi), 0);
    checkOutput({tag, "_no_resp"}, int'(no_resp), 0);
    checkOutput({tag, "_viol"}, int'(viol), 0);
    checkOutput({tag, "_spurious"}, int'(spurious), 0);
    checkOutput({tag, "_retrig"}, int'(retrig_cnt), 0);
    checkOutput({tag, "_max"}, int'(max_delay), 0);
  endtask

  // Monitor: every presented report or spurious pulse must match the queue head.
  always @(negedge clock) begin
    if (!reset) begin
      if (meas_valid) begin
        bit ok;
        ok = (exp_q.size() > 0) && !exp_q[0].is_spur;
        checkOutput("report_expected", int'(ok), 1);
        if (ok) begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("meas_delay", int'(meas_delay), e.delay);
          checkOutput("meas_src", int'(meas_src), e.src);
          checkOutput("meas_multi", int'(meas_multi), int'(e.multi));
          checkOutput("no_resp", int'(no_resp), int'(e.no_resp));
          checkOutput("viol", int'(viol), int'(e.viol));
        end
      end
      if (spurious) begin
        bit ok;
        ok = (exp_q.size() > 0) && exp_q[0].is_spur;
        checkOutput("spurious_expected", int'(ok), 1);
        if (ok) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    stim  = 4'b0000;
    resp  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1 reset = 1'b0;
    wait_cycles(3);

    // Directed cases from the block's intended use
    applyStimulus(4'b0001, 15, 1'b1);
    applyStimulus(4'b0010, 16, 1'b1);
    applyStimulus(4'b1000, 13, 1'b1);
    applyStimulus(4'b1000, 12, 1'b1);
    applyStimulus(4'b1100, 0, 1'b0);
    check_counters();
    applyRetrig(4'b0001, 5, 4'b0100, 12);
    check_counters();
    applySpurious();
    check_counters();

    // Reset in the middle of a measurement: nothing may be reported
    wait_cycles(1);
    stim = stim ^ 4'b0100;
    wait_cycles(6);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("midreset");
    @(posedge clock);
    #1 reset = 1'b0;
    retrig_model = 0;
    max_model    = 0;
    wait_cycles(TIMEOUT + 8);

    applyStimulus(4'b0001, 7, 1'b1);
    applyStimulus(4'b0010, 14, 1'b1);
    applyStimulus(4'b0100, 3, 1'b1);
    check_counters();
    applyStimulus(4'b1000, 0, 1'b0);
    check_counters();
    applyStimulus(4'b0110, 0, 1'b1);
    applyStimulus(4'b0001, TIMEOUT, 1'b1);
    applyStimulus(4'b1010, TIMEOUT + 1, 1'b1);
    check_counters();

    for (int n = 0; n < 120; n++) begin
      int               kind;
      logic [N_IN-1:0]  mask;
      int               d;
      kind = $urandom_range(0, 9);
      mask = 4'($urandom_range(1, 15));
      if (kind == 0) begin
        applySpurious();
      end else if (kind == 1) begin
        logic [N_IN-1:0] m2;
        m2 = 4'($urandom_range(1, 15));
        applyRetrig(mask, $urandom_range(1, 20), m2, $urandom_range(1, 40));
      end else if (kind == 2) begin
        applyStimulus(mask, 0, 1'b0);
      end else begin
        if ($urandom_range(0, 4) == 0) d = $urandom_range(55, 70);
        else                           d = $urandom_range(0, 20);
        applyStimulus(mask, d, 1'b1);
      end
      check_counters();
    end

    wait_cycles(5);
    checkOutput("pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
